// File: rtl/b2b_board_receiver_if.sv
// b2b_board_receiver_if: SpyBuffer read side (fifo_*) and downstream handshake (out_*); master = receiver, slave = environment
interface b2b_board_receiver_if #(
  parameter int DATA_WIDTH = 65
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_read_enable;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sop;
  logic                  out_eop;
  logic                  out_error;
  modport master (
    input  fifo_data, fifo_empty, out_ready,
    output fifo_read_enable, out_data, out_valid, out_sop, out_eop, out_error
  );
  modport slave (
    output fifo_data, fifo_empty, out_ready,
    input  fifo_read_enable, out_data, out_valid, out_sop, out_eop, out_error
  );
endinterface

// File: rtl/b2b_board_receiver.sv
// b2b_board_receiver: frames SpyBuffer words into header/payload/footer events; ports clock, reset, bus (fifo read + out handshake), event_count, error_count
module b2b_board_receiver #(
  parameter int DATA_WIDTH = 65,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  b2b_board_receiver_if.master  bus,
  output logic [CNT_WIDTH-1:0]  event_count,
  output logic [CNT_WIDTH-1:0]  error_count
);
  typedef enum logic {WAIT_HDR, PAYLOAD} state_e;
  state_e                state_q, state_d;
  logic                  rd_q;
  logic [2:0]            cnt_q;
  logic [1:0]            wp_q, rp_q;
  logic [DATA_WIDTH+2:0] mem_q [4];
  logic [CNT_WIDTH-1:0]  wc_q, wc_d, ev_q, ev_d, er_q, er_d;
  logic                  meta, hdr, ftr, in_pay, fwd, drop, sop, eop, err, live, pop, unused_ok;
  always_comb begin
    meta      = bus.fifo_data[DATA_WIDTH-1];
    hdr       = rd_q && meta && bus.fifo_data[63:56] == 8'hAB;
    ftr       = rd_q && meta && bus.fifo_data[63:56] == 8'hCD;
    in_pay    = state_q == PAYLOAD;
    fwd       = hdr || (rd_q && in_pay);
    drop      = rd_q && !in_pay && !hdr;
    sop       = hdr;
    eop       = in_pay && ftr;
    err       = (hdr && in_pay) || (eop && (bus.fifo_data[15:0] != 16'(wc_q) || &wc_q));
    state_d   = hdr ? PAYLOAD : eop ? WAIT_HDR : state_q;
    wc_d      = hdr ? '0 : (rd_q && in_pay && !ftr && !(&wc_q)) ? wc_q + CNT_WIDTH'(1) : wc_q;
    ev_d      = ev_q + CNT_WIDTH'(eop);
    er_d      = er_q + CNT_WIDTH'(drop || err);
    live      = cnt_q != 3'd0 && !reset;
    pop       = live && bus.out_ready;
    unused_ok = ^bus.fifo_data;
  end
  assign bus.fifo_read_enable = !reset && !bus.fifo_empty && (cnt_q + 3'(rd_q)) < 3'd4;
  assign bus.out_valid = live;
  assign {bus.out_error, bus.out_eop, bus.out_sop, bus.out_data} = live ? mem_q[rp_q] : '0;
  assign event_count = reset ? '0 : ev_q;
  assign error_count = reset ? '0 : er_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_HDR;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      wc_q    <= '0;
      ev_q    <= '0;
      er_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= bus.fifo_read_enable;
      cnt_q   <= cnt_q + 3'(fwd) - 3'(pop);
      wp_q    <= wp_q + 2'(fwd);
      rp_q    <= rp_q + 2'(pop);
      wc_q    <= wc_d;
      ev_q    <= ev_d;
      er_q    <= er_d;
    end
    if (fwd) mem_q[wp_q] <= {err, eop, sop, bus.fifo_data};
  end
endmodule

// File: tb/tb_b2b_board_receiver.sv
// tb_b2b_board_receiver: scoreboard bench driving a registered SpyBuffer model and checking framed output
module tb_b2b_board_receiver;
  localparam int DW = 65;
  localparam int CW = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [CW-1:0] event_count, error_count;
  b2b_board_receiver_if #(.DATA_WIDTH(DW)) bif ();
  b2b_board_receiver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bif),
    .event_count (event_count),
    .error_count (error_count)
  );
  typedef struct { logic [DW-1:0] w; logic fwd; } src_t;
  typedef struct { logic [DW-1:0] w; logic sop, eop, err; } exp_t;
  src_t src[$];
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int ready_mode = 0;
  logic rand_empty = 1'b0;
  logic rd_seen = 1'b0, cur_fwd = 1'b0, prev_rd = 1'b0, hold_v = 1'b0, xfer;
  logic [DW+2:0] hold_w;
  int occ = 0;
  exp_t e;
  task automatic check(string tag, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [DW-1:0] hw(logic [7:0] m, logic [15:0] lo);
    return {1'b1, m, 40'h0, lo};
  endfunction
  function automatic logic [DW-1:0] dw();
    return {1'b0, 32'($urandom()), 32'($urandom())};
  endfunction
  task automatic put(logic [DW-1:0] w, logic fwd, logic s, logic eo, logic er);
    src_t x;
    exp_t y;
    x.w = w; x.fwd = fwd;
    src.push_back(x);
    if (fwd) begin
      y.w = w; y.sop = s; y.eop = eo; y.err = er;
      exp_q.push_back(y);
    end
  endtask
  task automatic clean_event(int n);
    put(hw(8'hAB, 16'd5), 1, 1, 0, 0);
    for (int i = 0; i < n; i++) put(dw(), 1, 0, 0, 0);
    put(hw(8'hCD, 16'(n)), 1, 0, 1, 0);
  endtask
  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    src.delete();
    exp_q.delete();
    rand_empty = 1'b0;
    ready_mode = 0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask
  task automatic drain(string tag);
    int n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check({tag, "_timeout"}, n < 2000, 1);
    repeat (6) @(posedge clock);
    @(negedge clock);
    check({tag, "_idle"}, bif.out_valid, 0);
  endtask
  initial forever #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial forever begin
    @(posedge clock);
    #1;
    if (rd_seen && src.size() > 0) begin
      bif.fifo_data = src[0].w;
      cur_fwd = src[0].fwd;
      void'(src.pop_front());
    end else cur_fwd = 1'b0;
    bif.fifo_empty = src.size() == 0 || (rand_empty && $urandom_range(1) == 1);
    bif.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~bif.out_ready : 1'b0;
  end
  initial forever begin
    @(negedge clock);
    rd_seen = bif.fifo_read_enable;
    if (reset) begin
      occ = 0;
      prev_rd = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (bif.fifo_read_enable) check("rd_limit", (occ + int'(prev_rd)) < 4, 1);
      if (hold_v) begin
        check("hold_valid", bif.out_valid, 1);
        check("hold_data", {bif.out_error, bif.out_eop, bif.out_sop, bif.out_data}, hold_w);
      end
      xfer = bif.out_valid && bif.out_ready;
      if (xfer) begin
        if (exp_q.size() == 0) check("unexpected_word", bif.out_data, 0);
        else begin
          e = exp_q.pop_front();
          check("data", bif.out_data, e.w);
          check("sop", bif.out_sop, e.sop);
          check("eop", bif.out_eop, e.eop);
          check("err", bif.out_error, e.err);
        end
      end
      hold_v = bif.out_valid && !bif.out_ready;
      hold_w = {bif.out_error, bif.out_eop, bif.out_sop, bif.out_data};
      occ = occ + int'(prev_rd && cur_fwd) - int'(xfer);
      prev_rd = bif.fifo_read_enable;
    end
  end
  initial begin
    bif.fifo_data = '0;
    bif.fifo_empty = 1'b1;
    bif.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_state", {bif.fifo_read_enable, bif.out_valid, bif.out_sop, bif.out_eop,
                          bif.out_error, bif.out_data, event_count, error_count}, 0);
    do_reset();
    clean_event(3);
    drain("t1");
    check("t1_ev", event_count, 1);
    check("t1_er", error_count, 0);
    do_reset();
    put(hw(8'hAB, 16'd5), 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) put(dw(), 1, 0, 0, 0);
    put(hw(8'hCD, 16'd2), 1, 0, 1, 1);
    drain("t2");
    check("t2_ev", event_count, 1);
    check("t2_er", error_count, 1);
    do_reset();
    put(dw(), 0, 0, 0, 0);
    put(dw(), 0, 0, 0, 0);
    clean_event(3);
    drain("t3");
    check("t3_ev", event_count, 1);
    check("t3_er", error_count, 2);
    do_reset();
    put(hw(8'hAB, 16'd1), 1, 1, 0, 0);
    put(dw(), 1, 0, 0, 0);
    put(hw(8'hAB, 16'd2), 1, 1, 0, 1);
    put(dw(), 1, 0, 0, 0);
    put(dw(), 1, 0, 0, 0);
    put(hw(8'hCD, 16'd2), 1, 0, 1, 0);
    drain("t4");
    check("t4_ev", event_count, 1);
    check("t4_er", error_count, 1);
    do_reset();
    rand_empty = 1'b1;
    ready_mode = 1;
    clean_event(18);
    drain("t5");
    check("t5_ev", event_count, 1);
    check("t5_er", error_count, 0);
    do_reset();
    ready_mode = 2;
    put(dw(), 0, 0, 0, 0);
    put(hw(8'hAB, 16'd7), 1, 1, 0, 0);
    put(dw(), 1, 0, 0, 0);
    put(dw(), 1, 0, 0, 0);
    repeat (12) @(posedge clock);
    @(negedge clock);
    check("t6_pre_valid", bif.out_valid, 1);
    check("t6_pre_er", error_count, 1);
    @(posedge clock); #2;
    reset = 1'b1;
    src.delete();
    exp_q.delete();
    @(negedge clock);
    check("t6_rst_outs", {bif.fifo_read_enable, bif.out_valid, bif.out_sop, bif.out_eop,
                          bif.out_error, bif.out_data, event_count, error_count}, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    ready_mode = 0;
    clean_event(2);
    drain("t6");
    check("t6_ev", event_count, 1);
    check("t6_er", error_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/b2b_board_receiver.md
B2B_BOARD_RECEIVER -- requirements
Module: b2b_board_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 65, meaning the FIFO word width; bit DATA_WIDTH-1 is the metadata flag.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the word, event and error counters.
REQ-003 SHALL have port clock, input, 1, the single TP clock (nominally 200 MHz).
REQ-004 SHALL have port reset, input, 1: synchronous, active-high, sampled on the rising edge of clock.
REQ-005 SHALL have port fifo_data, input, DATA_WIDTH, the read data of one output-board SpyBuffer.
REQ-006 SHALL have port fifo_empty, input, 1, the empty flag of that SpyBuffer.
REQ-007 SHALL have port fifo_read_enable, output, 1, the read strobe to that SpyBuffer.
REQ-008 SHALL have port out_data, output, DATA_WIDTH, the reassembled word.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-010 SHALL have ports out_sop, out_eop and out_error, each output, 1, sideband qualifiers of out_data.
REQ-011 SHALL have ports event_count and error_count, each output, CNT_WIDTH, status counters.

Function
REQ-012 SHALL treat fifo_data as valid exactly one cycle after a cycle in which fifo_read_enable=1 (registered SpyBuffer read).
REQ-013 SHALL classify words as follows:
- Header: meta=1 and bits[63:56]=8'hAB.
- Footer: meta=1 and bits[63:56]=8'hCD.
- Other meta word (meta=1, any other marker): payload.
- Data word (meta=0): payload.
REQ-014 SHALL buffer words in an internal 4-entry FIFO.
REQ-015 SHALL assert fifo_read_enable only when fifo_empty=0 and (occupancy + reads in flight) < 4; the buffer SHALL never overflow.
REQ-016 SHALL present out_valid no earlier than 2 cycles after the fifo_read_enable that fetched the word.
REQ-017 SHALL sustain 1 word/cycle while fifo_empty=0 and out_ready=1.
REQ-018 SHALL hold out_data, out_sop, out_eop and out_error stable while out_valid=1 and out_ready=0; a word transfers on out_valid=1 and out_ready=1.
REQ-019 SHALL implement FSM states WAIT_HDR and PAYLOAD, with the following transitions and actions:
- WAIT_HDR, header: forward with out_sop=1, clear word counter, go to PAYLOAD.
- WAIT_HDR, payload or footer: drop (not forwarded), error_count+1, stay in WAIT_HDR.
- PAYLOAD, payload: forward, word counter+1 (saturating at all-ones).
- PAYLOAD, footer: forward with out_eop=1, event_count+1, go to WAIT_HDR.
- PAYLOAD, header: forward with out_sop=1 and out_error=1 (previous event truncated), error_count+1, clear counter, stay in PAYLOAD.
REQ-020 SHALL set out_error=1 on the footer word if footer bits[15:0] differ from the payload word count (counter truncated/zero-extended to 16 bits), and SHALL increment error_count in that case, while still counting the event.
REQ-021 SHALL set out_error=1 on the footer if the word counter saturated.
REQ-022 SHALL make event_count and error_count wrap modulo 2^CNT_WIDTH.
REQ-023 SHALL keep out_sop, out_eop and out_error at 0 for ordinary payload words.
REQ-024 SHALL apply counter updates when the word is classified, not when it transfers downstream.

Reset
REQ-025 SHALL, while reset=1:
- drive fifo_read_enable=0, out_valid=0, out_sop=0, out_eop=0, out_error=0, out_data=0, event_count=0, error_count=0;
- flush the internal buffer;
- discard in-flight reads;
- enter WAIT_HDR.
REQ-026 SHALL, on reset mid-event, drop the partial event; the first post-reset word SHALL be classified in WAIT_HDR.
REQ-027 SHALL assert fifo_read_enable no earlier than the first cycle after reset deasserts.

Verification
REQ-028 SHALL cover: header(AB,id=5), 3 data words, footer(CD, count=3) with out_ready=1 -> 5 words out in order; sop on 1st, eop on 5th, no error; event_count=1, error_count=0.
REQ-029 SHALL cover: same event with footer count=2 -> footer out with out_error=1 and eop=1; event_count=1, error_count=1.
REQ-030 SHALL cover: 2 data words then a full valid event -> the data words are dropped, error_count=2, the event passes cleanly, event_count=1.
REQ-031 SHALL cover: header, 1 data word, header, 2 data words, footer(count=2) -> 2nd header has sop=1 and error=1; event_count=1, error_count=1.
REQ-032 SHALL cover: 20-word event with out_ready toggling 1/0 every cycle and fifo_empty random -> no loss, duplication or reorder; fifo_read_enable never fires with buffer+in-flight at 4.
REQ-033 SHALL cover: reset pulsed for 1 cycle after 2 payload words of an event -> outputs zero during reset; the next valid event is forwarded cleanly; event_count=1.
